// File: rtl/csr_led_ctrl.sv
// CSR-mapped LED sequencer: CTRL/TIME registers drive the LED as OFF, ON, BLINK or PWM
// and raise a one-cycle wrap pulse at the end of each period.
package csr_led_ctrl_pkg;
  typedef logic [11:0] csr_addr_t;
  typedef logic [4:0]  r;
  typedef logic [31:0] word;
  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSR_RW   = 3'b001,
    CSR_RS   = 3'b010,
    CSR_RC   = 3'b011,
    CSR_RWI  = 3'b101,
    CSR_RSI  = 3'b110,
    CSR_RCI  = 3'b111
  } csr_t;
endpackage

module csr_led_ctrl
  import csr_led_ctrl_pkg::*;
#(
  parameter csr_addr_t CtrlAddr = 12'h001,
  parameter csr_addr_t TimeAddr = 12'h002
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  csr_addr_t addr,
  input  r          rs1,
  input  r          rd,
  input  csr_t      op,
  input  word       in,
  output word       old,
  output logic      led,
  output logic      wrap
);

  logic [1:0]  mode_reg;
  logic        invert_reg;
  logic        wrap_en_reg;
  logic [15:0] prescale_reg;
  logic [15:0] period_reg;
  logic [15:0] compare_reg;
  logic [15:0] presc_reg;
  logic [15:0] phase_reg;
  logic        blink_reg;
  logic        led_reg;
  logic        wrap_reg;

  word  ctrl_val;
  word  time_val;
  word  wdata;
  logic sel_ctrl;
  logic sel_time;
  logic do_write;
  logic restart;
  logic tick;
  logic wrap_event;
  logic raw;
  logic unused_rd;

  // rd only names the destination; reads have no side effects here.
  assign unused_rd = ^rd;

  assign ctrl_val = {prescale_reg, 7'd0, led_reg, 4'd0, wrap_en_reg, invert_reg, mode_reg};
  assign time_val = {compare_reg, period_reg};
  assign sel_ctrl = en && (addr == CtrlAddr);
  assign sel_time = en && (addr == TimeAddr);

  always_comb begin
    old = '0;
    if (sel_ctrl) begin
      old = ctrl_val;
    end else if (sel_time) begin
      old = time_val;
    end
  end

  // Set/clear forms with a zero rs1 field are pure reads.
  always_comb begin
    wdata    = old;
    do_write = 1'b0;
    case (op)
      CSR_RW, CSR_RWI: begin
        wdata    = in;
        do_write = 1'b1;
      end
      CSR_RS, CSR_RSI: begin
        wdata    = old | in;
        do_write = (rs1 != '0);
      end
      CSR_RC, CSR_RCI: begin
        wdata    = old & ~in;
        do_write = (rs1 != '0);
      end
      default: ;
    endcase
  end

  assign restart    = (sel_ctrl || sel_time) && do_write;
  assign tick       = (presc_reg == prescale_reg);
  assign wrap_event = tick && (phase_reg == period_reg) && !restart;

  always_comb begin
    raw = 1'b0;
    case (mode_reg)
      2'd0: raw = 1'b0;
      2'd1: raw = 1'b1;
      2'd2: raw = blink_reg;
      2'd3: raw = (phase_reg < compare_reg);
      default: raw = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_reg     <= '0;
      invert_reg   <= 1'b0;
      wrap_en_reg  <= 1'b0;
      prescale_reg <= '0;
      period_reg   <= '0;
      compare_reg  <= '0;
    end else begin
      if (sel_ctrl && do_write) begin
        mode_reg     <= wdata[1:0];
        invert_reg   <= wdata[2];
        wrap_en_reg  <= wdata[3];
        prescale_reg <= wdata[31:16];
      end
      if (sel_time && do_write) begin
        period_reg  <= wdata[15:0];
        compare_reg <= wdata[31:16];
      end
    end
  end

  // A register write restarts the sequence and wins over a coincident tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg <= '0;
      phase_reg <= '0;
      blink_reg <= 1'b0;
    end else if (restart) begin
      presc_reg <= '0;
      phase_reg <= '0;
      blink_reg <= 1'b0;
    end else if (tick) begin
      presc_reg <= '0;
      phase_reg <= (phase_reg == period_reg) ? 16'd0 : phase_reg + 16'd1;
      if (wrap_event) begin
        blink_reg <= ~blink_reg;
      end
    end else begin
      presc_reg <= presc_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_reg  <= 1'b0;
      wrap_reg <= 1'b0;
    end else begin
      led_reg  <= raw ^ invert_reg;
      wrap_reg <= wrap_event && wrap_en_reg && mode_reg[1];
    end
  end

  assign led  = led_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_csr_led_ctrl.sv
// Bench for csr_led_ctrl: directed scenarios plus random CSR traffic, checked against
// a closed-form model that derives counter/blink state from cycles since the last restart.
module tb_csr_led_ctrl;
  import csr_led_ctrl_pkg::*;

  localparam csr_addr_t CTRL = 12'h001;
  localparam csr_addr_t TIME = 12'h002;

  logic      clk;
  logic      reset;
  logic      en;
  csr_addr_t addr;
  r          rs1;
  r          rd;
  csr_t      op;
  word       in;
  word       old;
  logic      led;
  logic      wrap;

  int checks;
  int failures;

  word    m_ctrl;
  word    m_time;
  longint m_k;
  logic   m_led;
  logic   m_wrap;

  csr_led_ctrl #(.CtrlAddr(CTRL), .TimeAddr(TIME)) dut (
    .clk(clk), .reset(reset), .en(en), .addr(addr), .rs1(rs1), .rd(rd),
    .op(op), .in(in), .old(old), .led(led), .wrap(wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input word obs, input word exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint m_pre();
    return longint'(m_ctrl[31:16]) + 1;
  endfunction

  function automatic longint m_per();
    return longint'(m_time[15:0]) + 1;
  endfunction

  // Wrap event happens in the current cycle if it is the last prescaler cycle of the last phase.
  function automatic logic m_evt();
    return ((m_k % m_pre()) == m_pre() - 1) && (((m_k / m_pre()) % m_per()) == m_per() - 1);
  endfunction

  function automatic logic m_raw();
    longint ticks;
    longint phase;
    logic   blink;
    ticks = m_k / m_pre();
    phase = ticks % m_per();
    blink = ((ticks / m_per()) % 2) == 1;
    case (m_ctrl[1:0])
      2'd0: return 1'b0;
      2'd1: return 1'b1;
      2'd2: return blink;
      default: return phase < longint'(m_time[31:16]);
    endcase
  endfunction

  function automatic word m_ctrl_read();
    word v;
    v = m_ctrl;
    v[8] = m_led;
    return v;
  endfunction

  // One clock cycle: apply inputs just after an edge, check old mid-cycle, check outputs after the edge.
  task automatic cycle(input logic e, input csr_addr_t a, input r s1, input csr_t o, input word d);
    word  cur;
    word  nv;
    logic wr;
    logic raw;
    logic evt;
    en   = e;
    addr = a;
    rs1  = s1;
    rd   = 5'($urandom);
    op   = o;
    in   = d;
    #4;
    cur = '0;
    if (e && a == CTRL) cur = m_ctrl_read();
    else if (e && a == TIME) cur = m_time;
    chk("old", old, cur);
    nv = cur;
    wr = 1'b0;
    case (o)
      CSR_RW, CSR_RWI: begin nv = d; wr = 1'b1; end
      CSR_RS, CSR_RSI: begin nv = cur | d; wr = (s1 != 0); end
      CSR_RC, CSR_RCI: begin nv = cur & ~d; wr = (s1 != 0); end
      default: ;
    endcase
    wr  = wr && e && (a == CTRL || a == TIME);
    raw = m_raw();
    evt = m_evt();
    m_wrap = evt && !wr && m_ctrl[3] && m_ctrl[1];
    m_led  = raw ^ m_ctrl[2];
    if (wr) begin
      if (a == CTRL) m_ctrl = nv & 32'hFFFF_000F;
      else m_time = nv;
      m_k = 0;
    end else begin
      m_k++;
    end
    @(posedge clk);
    #1;
    chk("led", word'(led), word'(m_led));
    chk("wrap", word'(wrap), word'(m_wrap));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, CSR_NONE, '0);
  endtask

  task automatic model_reset();
    m_ctrl = '0;
    m_time = '0;
    m_k    = 0;
    m_led  = 1'b0;
    m_wrap = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    en   = 1'b1;
    op   = CSR_NONE;
    addr = CTRL;
    #1;
    chk({tag, "_ctrl"}, old, 32'h0);
    addr = TIME;
    #1;
    chk({tag, "_time"}, old, 32'h0);
    chk({tag, "_led"}, word'(led), 32'h0);
    chk({tag, "_wrap"}, word'(wrap), 32'h0);
    en = 1'b0;
  endtask

  initial begin
    csr_t ops [6];
    csr_t ro;
    csr_addr_t ra;
    word rv;
    ops = '{CSR_RW, CSR_RS, CSR_RC, CSR_RWI, CSR_RSI, CSR_RCI};
    checks   = 0;
    failures = 0;
    reset = 1'b0;
    en    = 1'b0;
    addr  = '0;
    rs1   = '0;
    rd    = '0;
    op    = CSR_NONE;
    in    = '0;
    model_reset();
    #12;
    check_reset_state("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reads with rs1=0 change nothing.
    cycle(1'b1, CTRL, 5'd0, CSR_RS, 32'h0);
    cycle(1'b1, TIME, 5'd0, CSR_RS, 32'h0);
    idle(2);

    // ON, readback with live led bit, then clear back to OFF.
    cycle(1'b1, CTRL, 5'd1, CSR_RW, 32'h0000_0001);
    cycle(1'b1, CTRL, 5'd0, CSR_RS, 32'h0);
    en = 1'b1; addr = CTRL; op = CSR_NONE;
    #1;
    chk("ctrl_readback", old, 32'h0000_0101);
    cycle(1'b1, CTRL, 5'd1, CSR_RC, 32'h1);
    idle(2);

    // BLINK with prescale=1, period=3, wrap enabled.
    cycle(1'b1, TIME, 5'd1, CSR_RW, 32'h0000_0003);
    cycle(1'b1, CTRL, 5'd1, CSR_RW, 32'h0001_000A);
    idle(40);

    // PWM pattern, then compare boundaries, then inverted.
    cycle(1'b1, TIME, 5'd1, CSR_RW, 32'h0002_0003);
    cycle(1'b1, CTRL, 5'd1, CSR_RW, 32'h0000_000B);
    idle(12);
    cycle(1'b1, TIME, 5'd1, CSR_RW, 32'h0000_0003);
    idle(8);
    cycle(1'b1, TIME, 5'd1, CSR_RW, 32'h0005_0003);
    idle(8);
    cycle(1'b1, CTRL, 5'd2, CSR_RSI, 32'h4);
    cycle(1'b1, TIME, 5'd1, CSR_RW, 32'h0002_0003);
    idle(12);

    // TIME write coinciding with a wrap event suppresses the pulse and restarts.
    cycle(1'b1, CTRL, 5'd1, CSR_RW, 32'h0001_000A);
    idle(3);
    for (int i = 0; i < 100 && !m_evt(); i++) idle(1);
    cycle(1'b1, TIME, 5'd1, CSR_RW, 32'h0000_0003);
    idle(10);

    // Immediate set with rs1=0 is a read; counters keep running.
    idle(5);
    cycle(1'b1, CTRL, 5'd0, CSR_RSI, 32'h0);
    idle(20);

    // Asynchronous reset mid-BLINK.
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_state("midreset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(3);

    // Random CSR traffic with small prescale/period so activity is frequent.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        ro = ops[$urandom_range(0, 5)];
        ra = ($urandom_range(0, 1) == 0) ? CTRL : TIME;
        if (ra == CTRL) rv = {16'($urandom_range(0, 3)), 16'($urandom)};
        else rv = {16'($urandom_range(0, 9)), 16'($urandom_range(0, 7))};
        cycle(1'b1, ra, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), ro, rv);
      end else if ($urandom_range(0, 7) == 0) begin
        cycle(1'b1, ($urandom_range(0, 1) == 0) ? CTRL : 12'h7FF, 5'd0, CSR_RS, 32'h0);
      end else begin
        idle(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
